// File: rtl/hazard_controller_pkg.sv
// hazard_controller_pkg: shared FSM encoding, forwarding selects and forwarding priority helper
package hazard_controller_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  // the younger EX/MEM result wins; $0 is hardwired zero so it is never forwarded
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic mem_rw,
                                         input logic [4:0] mem_dst, input logic wb_rw,
                                         input logic [4:0] wb_dst);
    return (mem_rw && mem_dst != 5'd0 && mem_dst == src) ? FWD_EXMEM :
           (wb_rw && wb_dst != 5'd0 && wb_dst == src) ? FWD_MEMWB : FWD_REG;
  endfunction
endpackage

// File: rtl/hazard_controller_fwd.sv
// hazard_controller_fwd: combinational EX-stage operand forwarding select
module hazard_controller_fwd
  import hazard_controller_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_writereg,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_writereg,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);
  assign fwd_a = fwd_sel(ex_rs, mem_regwrite, mem_writereg, wb_regwrite, wb_writereg);
  assign fwd_b = fwd_sel(ex_rt, mem_regwrite, mem_writereg, wb_regwrite, wb_writereg);
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: 5-stage MIPS pipeline stall/flush/bubble sequencing, memory-wait FSM,
// stall statistics and forwarding select
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic             ex_branch_tk,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_writereg,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_writereg,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic             freeze_back,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  state_t           state_q, state_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             memwait, load_use;
  logic [1:0]       fwd_a_w, fwd_b_w;

  hazard_controller_fwd u_fwd (
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_regwrite(mem_regwrite), .mem_writereg(mem_writereg),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg),
    .fwd_a(fwd_a_w), .fwd_b(fwd_b_w)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (state_q == RUN) begin
      if (mem_req && !mem_ack) begin
        state_d    = MEM_WAIT;
        wait_cnt_d = WW'(1);
      end
    end else if (mem_ack || wait_cnt_q == WW'(MAX_WAIT)) begin
      state_d       = RUN;
      wait_cnt_d    = '0;
      mem_timeout_d = mem_timeout_q | ~mem_ack;
    end else begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end
    stall_count_d = (stall_pc && !(&stall_count_q)) ? stall_count_q + CNT_W'(1) : stall_count_q;
  end

  // memory wait outranks everything; branch/jump/load-use are simply deferred while frozen
  always_comb begin
    memwait     = (state_q == RUN) ? (mem_req && !mem_ack) : !mem_ack;
    load_use    = ex_memread && ex_rt != 5'd0 &&
                  (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    stall_pc    = !reset && (memwait || (!ex_branch_tk && load_use));
    stall_ifid  = stall_pc;
    freeze_back = !reset && memwait;
    flush_ifid  = !reset && !memwait && (ex_branch_tk || (!load_use && id_jump));
    bubble_idex = !reset && !memwait && (ex_branch_tk || load_use);
    fwd_a       = reset ? FWD_REG : fwd_a_w;
    fwd_b       = reset ? FWD_REG : fwd_b_w;
    mem_timeout = mem_timeout_q;
    stall_count = stall_count_q;
  end
endmodule
